exhaustive_stim_gen: RTL and testbench
======================================

// Module: exhaustive_stim_gen
// PURPOSE
// - Parametrised exhaustive-sweep stimulus engine for combinational lab blocks (N-input, M-output truth tables).
// - Drives every input vector 0..2^N_IN-1 and holds each for HOLD cycles.
// - Samples the DUT outputs at the end of each hold window and streams {stim,dut_out} per vector.
// - Compresses all samples into a CRC-style signature, giving a single pass/fail word per sweep.
// PARAMETERS
// - N_IN   4        DUT input width; sweep length = 2^N_IN vectors
// - N_OUT  2        DUT output width
// - HOLD   20       clock cycles each vector is held (>=1)
// - SIG_W  16       signature width; N_IN+N_OUT <= SIG_W
// - POLY   16'h1021 feedback polynomial (SIG_W bits)
// PORTS
// - clk           in   1            single clock, rising edge
// - rst_n         in   1            asynchronous, active-low reset
// - start         in   1            begin sweep (sampled in IDLE/DONE only)
// - abort         in   1            synchronous abort to IDLE
// - dut_out       in   N_OUT        DUT response to stim
// - stim          out  N_IN         registered vector applied to DUT
// - vec_idx       out  N_IN         current sweep index
// - busy          out  1            high in DRIVE
// - done          out  1            high in DONE
// - sample_valid  out  1            one-cycle pulse per captured vector
// - sample_data   out  N_IN+N_OUT   {stim,dut_out} captured
// - signature     out  SIG_W        running signature
// BEHAVIOUR
// - Reset (rst_n=0, any time incl. mid-sweep): state=IDLE; all outputs, vec_idx, hold_cnt, signature = 0.
// - FSM IDLE/DRIVE/DONE. IDLE|DONE + start -> DRIVE at next edge: vec_idx=0, hold_cnt=0, signature=0, done=0.
// - DRIVE: hold_cnt increments each cycle; stim constant for exactly HOLD cycles.
// - Cycle with hold_cnt==HOLD-1: dut_out sampled; at that edge sample_valid=1 (one cycle), sample_data={stim,dut_out},
//   signature <= ({sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? POLY : 0)) ^ zero-extend({stim,dut_out}).
// - Same edge: hold_cnt=0, vec_idx+1; if vec_idx was 2^N_IN-1 -> DONE (no wrap), busy=0, done=1.
// - Last sample_valid pulse coincides with first done cycle; done rises HOLD*2^N_IN cycles after DRIVE entry.
// - DONE: done, signature, stim, sample_data held until start or reset.
// - start while DRIVE: ignored. abort in DRIVE: -> IDLE at next edge, done stays 0, stim=0, signature retained.
// - abort and start same cycle: abort wins. abort on a sample edge: sample suppressed.
// - HOLD=1: new vector and sample every cycle, sample_valid continuously high through sweep.
// CONFIGURATION
// - GRAY_ORDER_EN defined: stim = vec_idx ^ (vec_idx>>1) (Gray order, one input toggles per step);
//   sample_data/signature use this Gray stim.
// - GRAY_ORDER_EN undefined: stim = vec_idx (binary order 0..2^N_IN-1).
// TESTING
// - Reset mid-sweep (N_IN=4, vector 7) -> all outputs 0 same cycle, IDLE; next start sweeps from 0.
// - N_IN=1,N_OUT=1,HOLD=3, dut_out=stim, binary: 2 samples 2'b00,2'b11 -> signature 16'h0003, done 6 cycles after DRIVE entry.
// - N_IN=4,HOLD=20, DUT=reference 4-in/2-out block -> 16 sample_valid pulses 20 cycles apart, stim 0..15, done after 320 cycles.
// - abort at vector 5 -> IDLE next edge, done=0, no further samples; start again -> full 16-vector sweep.
// - start pulsed during DRIVE -> no restart, vec_idx continues; start in DONE -> signature cleared, new sweep.
// - GRAY_ORDER_EN, N_IN=3 -> stim sequence 0,1,3,2,6,7,5,4; exactly one bit changes per step.

Source files
------------

// File: rtl/exhaustive_stim_gen.sv
// Exhaustive-sweep stimulus engine: walks every N_IN-bit input vector, samples the DUT
// response and folds it into a CRC signature. Define GRAY_ORDER_EN for Gray-order stimulus.
module exhaustive_stim_gen #(
    parameter int                N_IN  = 4,
    parameter int                N_OUT = 2,
    parameter int                HOLD  = 20,
    parameter int                SIG_W = 16,
    parameter logic [SIG_W-1:0]  POLY  = 16'h1021
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_OUT-1:0]        dut_out,
    output logic [N_IN-1:0]         stim,
    output logic [N_IN-1:0]         vec_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    sample_valid,
    output logic [N_IN+N_OUT-1:0]   sample_data,
    output logic [SIG_W-1:0]        signature
);
    localparam int SD_W = N_IN + N_OUT;
    localparam int HC_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(HOLD - 1);
    localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [HC_W-1:0]  hold_cnt;
    logic [SIG_W-1:0] sig_next;
    logic [SIG_W-1:0] sample_ext;

    function automatic logic [N_IN-1:0] to_stim(input logic [N_IN-1:0] idx);
`ifdef GRAY_ORDER_EN
        return idx ^ (idx >> 1);
`else
        return idx;
`endif
    endfunction

    // Shift-with-feedback, then fold in the zero-extended sample.
    always_comb begin
        sample_ext           = '0;
        sample_ext[SD_W-1:0] = {stim, dut_out};
        sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ sample_ext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            hold_cnt     <= '0;
            vec_idx      <= '0;
            stim         <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            signature    <= '0;
        end else begin
            sample_valid <= 1'b0;
            if (abort) begin
                // Abort outranks start and suppresses any sample due on this edge.
                state    <= S_IDLE;
                hold_cnt <= '0;
                vec_idx  <= '0;
                stim     <= '0;
                busy     <= 1'b0;
                done     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state     <= S_DRIVE;
                            hold_cnt  <= '0;
                            vec_idx   <= '0;
                            stim      <= to_stim('0);
                            signature <= '0;
                            busy      <= 1'b1;
                            done      <= 1'b0;
                        end
                    end
                    S_DRIVE: begin
                        if (hold_cnt == HC_LAST) begin
                            sample_valid <= 1'b1;
                            sample_data  <= {stim, dut_out};
                            signature    <= sig_next;
                            hold_cnt     <= '0;
                            if (vec_idx == IDX_LAST) begin
                                // Final vector: stim and vec_idx stay on it through DONE.
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                vec_idx <= vec_idx + 1'b1;
                                stim    <= to_stim(vec_idx + 1'b1);
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_exhaustive_stim_gen.sv
// Directed bench: a 4-in/2-out sweep against a reference block plus a tiny 1-in/1-out sweep.
module tb_exhaustive_stim_gen;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        start_b, abort_b;
    logic [1:0]  out_b;
    logic [3:0]  stim_b, vec_b;
    logic        busy_b, done_b, sv_b;
    logic [5:0]  sd_b;
    logic [15:0] sig_b;

    logic        start_s, abort_s;
    logic        stim_s, vec_s, busy_s, done_s, sv_s;
    logic [1:0]  sd_s;
    logic [15:0] sig_s;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_sig;
    int sweep_cnt;

    function automatic logic [1:0] refblk(input logic [3:0] x);
        return {x[0] ^ x[1] ^ x[2] ^ x[3], (x[3] & x[2]) | (x[1] & ~x[0])};
    endfunction

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [15:0] d);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ d;
    endfunction

    assign out_b = refblk(stim_b);

    exhaustive_stim_gen #(.N_IN(4), .N_OUT(2), .HOLD(20), .SIG_W(16), .POLY(16'h1021)) u_big (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .dut_out(out_b),
        .stim(stim_b), .vec_idx(vec_b), .busy(busy_b), .done(done_b),
        .sample_valid(sv_b), .sample_data(sd_b), .signature(sig_b));

    exhaustive_stim_gen #(.N_IN(1), .N_OUT(1), .HOLD(3), .SIG_W(16), .POLY(16'h1021)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .dut_out(stim_s),
        .stim(stim_s), .vec_idx(vec_s), .busy(busy_s), .done(done_s),
        .sample_valid(sv_s), .sample_data(sd_s), .signature(sig_s));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts a sweep on the big instance and runs stop_k cycles past DRIVE entry,
    // optionally pulsing start at cycle pulse_k to confirm it is ignored.
    task automatic sweep_big(input int stop_k, input int pulse_k);
        int cnt;
        logic [3:0] v;
        cnt = 0;
        exp_sig = 16'h0;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("entry_busy", busy_b, 1);
        check("entry_idx", vec_b, 0);
        check("entry_stim", stim_b, 0);
        check("entry_sig", sig_b, 0);
        check("entry_done", done_b, 0);
        for (int k = 1; k <= stop_k; k++) begin
            start_b = (k == pulse_k);
            @(negedge clk);
            if (k == pulse_k) check("start_ignored_idx", vec_b, k / 20);
            if (sv_b) begin
                v = cnt[3:0];
                check("sample_cycle", k, 20 * (cnt + 1));
                check("sample_data", sd_b, {v, refblk(v)});
                exp_sig = sig_step(exp_sig, {10'h0, v, refblk(v)});
                cnt++;
            end
            if (k == 319) check("done_early", done_b, 0);
        end
        start_b = 1'b0;
        if (stop_k == 320) begin
            check("final_done", done_b, 1);
            check("final_busy", busy_b, 0);
            check("final_count", cnt, 16);
            check("final_sig", sig_b, exp_sig);
            check("final_stim", stim_b, 15);
        end
        sweep_cnt = cnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int pulses;
        rst_n = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        start_s = 1'b0; abort_s = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stim", stim_b, 0);
        check("rst_idx", vec_b, 0);
        check("rst_busy", busy_b, 0);
        check("rst_done", done_b, 0);
        check("rst_sv", sv_b, 0);
        check("rst_sd", sd_b, 0);
        check("rst_sig", sig_b, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Small sweep: samples 2'b00 then 2'b11, signature 0x0003, done 6 cycles in.
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        check("s_busy", busy_s, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                check("s_sv0", sv_s, 1);
                check("s_sd0", sd_s, 2'b00);
                check("s_stim1", stim_s, 1);
            end
            if (k == 4) check("s_sv_low", sv_s, 0);
            if (k == 5) check("s_done_early", done_s, 0);
        end
        check("s_done", done_s, 1);
        check("s_sv1", sv_s, 1);
        check("s_sd1", sd_s, 2'b11);
        check("s_sig", sig_s, 16'h0003);
        check("s_busy_end", busy_s, 0);
        @(negedge clk);
        check("s_done_hold", done_s, 1);
        check("s_sig_hold", sig_s, 16'h0003);

        // Full sweep with a stray start mid-drive.
        sweep_big(320, 50);
        repeat (3) @(negedge clk);
        check("done_hold", done_b, 1);
        check("sig_hold", sig_b, exp_sig);

        // Restart from DONE clears signature, then reset at vector 7.
        sweep_big(150, 0);
        check("mid_idx7", vec_b, 7);
        check("mid_stim7", stim_b, 7);
        rst_n = 1'b0;
        #1;
        check("mr_stim", stim_b, 0);
        check("mr_idx", vec_b, 0);
        check("mr_busy", busy_b, 0);
        check("mr_sig", sig_b, 0);
        check("mr_sd", sd_b, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep_big(25, 0);
        check("post_rst_samples", sweep_cnt, 1);

        // Abort at vector 5 mid-hold.
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        sweep_big(110, 0);
        check("pre_abort_idx", vec_b, 5);
        abort_b = 1'b1;
        @(negedge clk);
        abort_b = 1'b0;
        check("ab_busy", busy_b, 0);
        check("ab_done", done_b, 0);
        check("ab_stim", stim_b, 0);
        check("ab_sig", sig_b, exp_sig);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (sv_b) pulses++;
        end
        check("ab_no_samples", pulses, 0);
        start_b = 1'b1; abort_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0; abort_b = 1'b0;
        check("ab_start_busy", busy_b, 0);
        sweep_big(320, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
